// File: rtl/pa_fdsu_pkg.sv
// Shared FDSU definitions: operand class record, special_sel and fflags bit positions.
package pa_fdsu_pkg;

    // Per-operand classification derived from raw IEEE bits
    typedef struct packed {
        logic inf;
        logic zero;
        logic id;
        logic cnan;
        logic snan;
        logic qnan;
        logic norm;
    } op_class_t;

    // out_special_sel layout: {0,qnan_op1,qnan_op0,cnan,lfn,inf,zero,0}
    localparam int unsigned SEL_W        = 8;
    localparam int unsigned SEL_ZERO     = 1;
    localparam int unsigned SEL_INF      = 2;
    localparam int unsigned SEL_LFN      = 3;
    localparam int unsigned SEL_CNAN     = 4;
    localparam int unsigned SEL_QNAN_OP0 = 5;
    localparam int unsigned SEL_QNAN_OP1 = 6;

    // fflags layout: {NV,DZ,OF,UF,NX}
    localparam int unsigned FF_W  = 5;
    localparam int unsigned FF_NX = 0;
    localparam int unsigned FF_UF = 1;
    localparam int unsigned FF_OF = 2;
    localparam int unsigned FF_DZ = 3;
    localparam int unsigned FF_NV = 4;

endpackage

// File: rtl/pa_fdsu_op_class.sv
// Combinational operand classifier: splits raw bits into inf/zero/id/nan/norm classes.
module pa_fdsu_op_class
    import pa_fdsu_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] op,
    output op_class_t            cls_c
);

    logic             sign_f;
    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;
    logic             exp_ones;
    logic             exp_zero;
    logic             man_zero;
    logic             man_msb;
    logic             man_low_zero;

    assign sign_f       = op[EXP_W+MAN_W];
    assign exp_f        = op[MAN_W +: EXP_W];
    assign man_f        = op[MAN_W-1:0];
    assign exp_ones     = &exp_f;
    assign exp_zero     = ~|exp_f;
    assign man_zero     = ~|man_f;
    assign man_msb      = man_f[MAN_W-1];
    assign man_low_zero = ~|man_f[MAN_W-2:0];

    // Class decode; denormals are treated as normal operands
    always_comb begin
        cls_c      = '0;
        cls_c.inf  = exp_ones & man_zero;
        cls_c.qnan = exp_ones & man_msb;
        cls_c.snan = exp_ones & !man_zero & !man_msb;
        cls_c.zero = exp_zero & man_zero;
        cls_c.id   = exp_zero & !man_zero;
        cls_c.cnan = exp_ones & man_msb & !sign_f & man_low_zero;
        cls_c.norm = !(cls_c.inf | cls_c.zero | cls_c.qnan | cls_c.snan | cls_c.cnan);
    end

endmodule

// File: rtl/pa_fdsu_special_pipe.sv
// Two-stage divide/sqrt special-case resolver with valid/ready handshake.
// Optional sticky fflags accumulator enabled by FDSU_SPECIAL_FFLAGS_ACC_EN.
module pa_fdsu_special_pipe
    import pa_fdsu_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                 forever_cpuclk,
    input  logic                 cpurst_b,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic [EXP_W+MAN_W:0] in_op0,
    input  logic [EXP_W+MAN_W:0] in_op1,
    input  logic                 in_div,
    input  logic                 in_sqrt,
    input  logic                 in_dqnan,
    input  logic                 flush,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [7:0]           out_special_sel,
    output logic [3:0]           out_special_sign,
    output logic [4:0]           out_fflags,
    output logic                 out_srt_skip,
    output logic                 out_op0_id,
    output logic                 out_op1_id,
    output logic                 out_op0_norm,
    output logic                 out_op1_norm,
`ifdef FDSU_SPECIAL_FFLAGS_ACC_EN
    input  logic                 acc_clr,
    output logic [4:0]           acc_fflags,
`endif
    output logic [EXP_W+MAN_W:0] out_result
);

    localparam int unsigned FLEN = 1 + EXP_W + MAN_W;
    localparam int unsigned PAY_W = MAN_W - 1;
    localparam logic [FLEN-1:0] CNAN_VAL = {1'b0, {EXP_W{1'b1}}, 1'b1, {PAY_W{1'b0}}};

    op_class_t cls0_c;
    op_class_t cls1_c;

    pa_fdsu_op_class #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls0 (.op(in_op0), .cls_c(cls0_c));
    pa_fdsu_op_class #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls1 (.op(in_op1), .cls_c(cls1_c));

    // Stage-1 state
    logic             s1_vld;
    op_class_t        s1_cls0;
    op_class_t        s1_cls1;
    logic             s1_div;
    logic             s1_sqrt;
    logic             s1_dqnan;
    logic             s1_sign0;
    logic             s1_sign1;
    logic [PAY_W-1:0] s1_pay0;
    logic [PAY_W-1:0] s1_pay1;

    logic s2_rdy_c;
    logic in_acc_c;
    logic s2_load_c;

    assign s2_rdy_c  = !out_vld | out_rdy;
    assign in_rdy    = !s1_vld | s2_rdy_c;
    assign in_acc_c  = in_vld & in_rdy & !flush;
    assign s2_load_c = s1_vld & s2_rdy_c & !flush;

    // Stage 1: capture operand classes, op and NaN mode
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            s1_vld   <= 1'b0;
            s1_cls0  <= '0;
            s1_cls1  <= '0;
            s1_div   <= 1'b0;
            s1_sqrt  <= 1'b0;
            s1_dqnan <= 1'b0;
            s1_sign0 <= 1'b0;
            s1_sign1 <= 1'b0;
            s1_pay0  <= '0;
            s1_pay1  <= '0;
        end else begin
            if (flush) begin
                s1_vld <= 1'b0;
            end else if (in_rdy) begin
                s1_vld <= in_vld;
            end
            if (in_acc_c) begin
                s1_cls0  <= cls0_c;
                s1_cls1  <= cls1_c;
                s1_div   <= in_div;
                s1_sqrt  <= in_sqrt;
                s1_dqnan <= in_dqnan;
                s1_sign0 <= in_op0[FLEN-1];
                s1_sign1 <= in_op1[FLEN-1];
                s1_pay0  <= in_op0[PAY_W-1:0];
                s1_pay1  <= in_op1[PAY_W-1:0];
            end
        end
    end

    logic             nv_c;
    logic             dz_c;
    logic             res_zero_c;
    logic             res_inf_c;
    logic             res_qnan_c;
    logic             dflt_nan_c;
    logic             sign_c;
    logic [SEL_W-1:0] sel_c;
    logic [FF_W-1:0]  fflags_c;
    logic             skip_c;
    logic [FLEN-1:0]  result_c;

    // Resolve exceptions, special result class, NaN source and final value
    always_comb begin
        nv_c       = 1'b0;
        dz_c       = 1'b0;
        res_zero_c = 1'b0;
        res_inf_c  = 1'b0;
        res_qnan_c = 1'b0;
        dflt_nan_c = 1'b0;
        sign_c     = 1'b0;
        sel_c      = '0;
        fflags_c   = '0;
        skip_c     = 1'b0;
        result_c   = '0;

        nv_c = (s1_div & (s1_cls0.snan | s1_cls1.snan | (s1_cls0.zero & s1_cls1.zero)
                          | (s1_cls0.inf & s1_cls1.inf)))
             | (s1_sqrt & (s1_cls0.snan | (s1_sign0 & (s1_cls0.norm | s1_cls0.inf))));
        dz_c = s1_div & s1_cls1.zero & s1_cls0.norm;

        res_zero_c = (s1_div & ((s1_cls0.zero & s1_cls1.norm)
                               | (!s1_cls0.inf & !s1_cls0.qnan & !s1_cls0.snan & !s1_cls0.cnan
                                  & s1_cls1.inf)))
                   | (s1_sqrt & s1_cls0.zero);
        res_inf_c  = (s1_div & s1_cls0.inf & !s1_cls1.inf & !s1_cls1.qnan & !s1_cls1.snan
                      & !s1_cls1.cnan)
                   | (s1_sqrt & s1_cls0.inf & !s1_sign0)
                   | dz_c;
        res_qnan_c = (s1_div & (s1_cls0.qnan | s1_cls1.qnan)) | (s1_sqrt & s1_cls0.qnan) | nv_c;

        // Invalid operations with no NaN input always produce the default NaN
        dflt_nan_c = (s1_div & ((s1_cls0.zero & s1_cls1.zero) | (s1_cls0.inf & s1_cls1.inf)))
                   | (s1_sqrt & s1_sign0 & (s1_cls0.norm | s1_cls0.inf));

        if (s1_div) begin
            sign_c = s1_sign0 ^ s1_sign1;
        end else if (s1_sqrt) begin
            sign_c = s1_sign0;
        end

        if (res_qnan_c) begin
            if (dflt_nan_c) begin
                sel_c[SEL_CNAN] = 1'b1;
            end else if (s1_dqnan & s1_cls0.snan) begin
                sel_c[SEL_QNAN_OP0] = 1'b1;
            end else if (s1_dqnan & s1_div & s1_cls1.snan) begin
                sel_c[SEL_QNAN_OP1] = 1'b1;
            end else if (s1_dqnan & s1_cls0.qnan) begin
                sel_c[SEL_CNAN]     = s1_cls0.cnan;
                sel_c[SEL_QNAN_OP0] = !s1_cls0.cnan;
            end else if (s1_dqnan & s1_div & s1_cls1.qnan) begin
                sel_c[SEL_CNAN]     = s1_cls1.cnan;
                sel_c[SEL_QNAN_OP1] = !s1_cls1.cnan;
            end else begin
                sel_c[SEL_CNAN] = 1'b1;
            end
        end else if (res_inf_c) begin
            sel_c[SEL_INF] = 1'b1;
        end else if (res_zero_c) begin
            sel_c[SEL_ZERO] = 1'b1;
        end
        sel_c[SEL_LFN] = 1'b0;

        fflags_c[FF_NV] = nv_c;
        fflags_c[FF_DZ] = dz_c;
        fflags_c[FF_OF] = 1'b0;
        fflags_c[FF_UF] = 1'b0;
        fflags_c[FF_NX] = 1'b0;

        skip_c = res_zero_c | res_inf_c | res_qnan_c | sel_c[SEL_LFN];

        if (sel_c[SEL_CNAN]) begin
            result_c = CNAN_VAL;
        end else if (sel_c[SEL_QNAN_OP0]) begin
            result_c = {s1_sign0, {EXP_W{1'b1}}, 1'b1, s1_pay0};
        end else if (sel_c[SEL_QNAN_OP1]) begin
            result_c = {s1_sign1, {EXP_W{1'b1}}, 1'b1, s1_pay1};
        end else if (sel_c[SEL_INF]) begin
            result_c = {sign_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (sel_c[SEL_ZERO]) begin
            result_c = {sign_c, {(FLEN-1){1'b0}}};
        end
    end

    // Stage 2: registered outputs, held while the consumer stalls
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            out_vld          <= 1'b0;
            out_special_sel  <= '0;
            out_special_sign <= '0;
            out_fflags       <= '0;
            out_srt_skip     <= 1'b0;
            out_op0_id       <= 1'b0;
            out_op1_id       <= 1'b0;
            out_op0_norm     <= 1'b0;
            out_op1_norm     <= 1'b0;
            out_result       <= '0;
        end else begin
            if (flush) begin
                out_vld <= 1'b0;
            end else if (s2_rdy_c) begin
                out_vld <= s1_vld;
            end
            if (s2_load_c) begin
                out_special_sel  <= sel_c;
                out_special_sign <= {sign_c, sign_c, sign_c, 1'b0};
                out_fflags       <= fflags_c;
                out_srt_skip     <= skip_c;
                out_op0_id       <= s1_cls0.id;
                out_op1_id       <= s1_cls1.id;
                out_op0_norm     <= s1_cls0.norm;
                out_op1_norm     <= s1_cls1.norm;
                out_result       <= result_c;
            end
        end
    end

`ifdef FDSU_SPECIAL_FFLAGS_ACC_EN
    logic out_fire_c;

    assign out_fire_c = out_vld & out_rdy;

    // Sticky flag accumulator; a clear coincident with delivery keeps only the new flags
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            acc_fflags <= '0;
        end else if (acc_clr) begin
            acc_fflags <= out_fire_c ? out_fflags : 5'b0;
        end else if (out_fire_c) begin
            acc_fflags <= acc_fflags | out_fflags;
        end
    end
`endif

endmodule

// File: tb/tb_pa_fdsu_special_pipe.sv
// Scoreboard bench for pa_fdsu_special_pipe (EXP_W=8, MAN_W=23).
module tb_pa_fdsu_special_pipe;

    logic        forever_cpuclk = 1'b0;
    logic        cpurst_b;
    logic        in_vld;
    logic        in_rdy;
    logic [31:0] in_op0;
    logic [31:0] in_op1;
    logic        in_div;
    logic        in_sqrt;
    logic        in_dqnan;
    logic        flush;
    logic        out_vld;
    logic        out_rdy;
    logic [7:0]  out_special_sel;
    logic [3:0]  out_special_sign;
    logic [4:0]  out_fflags;
    logic        out_srt_skip;
    logic        out_op0_id;
    logic        out_op1_id;
    logic        out_op0_norm;
    logic        out_op1_norm;
    logic [31:0] out_result;
`ifdef FDSU_SPECIAL_FFLAGS_ACC_EN
    logic        acc_clr;
    logic [4:0]  acc_fflags;
`endif

    always #5 forever_cpuclk = ~forever_cpuclk;

    pa_fdsu_special_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .forever_cpuclk  (forever_cpuclk),
        .cpurst_b        (cpurst_b),
        .in_vld          (in_vld),
        .in_rdy          (in_rdy),
        .in_op0          (in_op0),
        .in_op1          (in_op1),
        .in_div          (in_div),
        .in_sqrt         (in_sqrt),
        .in_dqnan        (in_dqnan),
        .flush           (flush),
        .out_vld         (out_vld),
        .out_rdy         (out_rdy),
        .out_special_sel (out_special_sel),
        .out_special_sign(out_special_sign),
        .out_fflags      (out_fflags),
        .out_srt_skip    (out_srt_skip),
        .out_op0_id      (out_op0_id),
        .out_op1_id      (out_op1_id),
        .out_op0_norm    (out_op0_norm),
        .out_op1_norm    (out_op1_norm),
`ifdef FDSU_SPECIAL_FFLAGS_ACC_EN
        .acc_clr         (acc_clr),
        .acc_fflags      (acc_fflags),
`endif
        .out_result      (out_result)
    );

    // Stimulus vector with hand-derived expected results
    typedef struct packed {
        logic [31:0] op0;
        logic [31:0] op1;
        logic        dv;
        logic        sq;
        logic        dq;
        logic [31:0] res;
        logic [7:0]  sel;
        logic [3:0]  sgn;
        logic [4:0]  ff;
        logic        skip;
        logic [3:0]  idn;   // {op0_id, op1_id, op0_norm, op1_norm}
    } vec_t;

    vec_t vt [16];
    vec_t drv_vec;
    vec_t sb_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_acc    = 0;
    logic done;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] op0, input logic [31:0] op1,
                                input logic dv, input logic sq, input logic dq,
                                input logic [31:0] res, input logic [7:0] sel,
                                input logic [3:0] sgn, input logic [4:0] ff,
                                input logic skip, input logic [3:0] idn);
        vec_t v;
        v.op0 = op0; v.op1 = op1; v.dv = dv; v.sq = sq; v.dq = dq;
        v.res = res; v.sel = sel; v.sgn = sgn; v.ff = ff; v.skip = skip; v.idn = idn;
        return v;
    endfunction

    // Scoreboard: push on accepted input, pop and compare on delivered output
    always @(negedge forever_cpuclk) begin
        if (!cpurst_b) begin
            sb_q.delete();
        end else begin
            if (out_vld && out_rdy) begin
                if (sb_q.size() == 0) begin
                    check_eq("spurious_out", 64'(out_vld), 64'd0);
                end else begin
                    vec_t e;
                    e = sb_q.pop_front();
                    check_eq("result", 64'(out_result), 64'(e.res));
                    check_eq("sel", 64'(out_special_sel), 64'(e.sel));
                    check_eq("sign", 64'(out_special_sign), 64'(e.sgn));
                    check_eq("fflags", 64'(out_fflags), 64'(e.ff));
                    check_eq("srt_skip", 64'(out_srt_skip), 64'(e.skip));
                    check_eq("id_norm", 64'({out_op0_id, out_op1_id, out_op0_norm, out_op1_norm}),
                             64'(e.idn));
                end
            end
            if (flush) sb_q.delete();
            if (in_vld && in_rdy && !flush) begin
                sb_q.push_back(drv_vec);
                n_acc++;
            end
        end
    end

    task automatic drive(input vec_t v);
        in_op0   = v.op0;
        in_op1   = v.op1;
        in_div   = v.dv;
        in_sqrt  = v.sq;
        in_dqnan = v.dq;
        drv_vec  = v;
        in_vld   = 1'b1;
    endtask

    // Present one vector (called just after a rising edge) and hold until accepted
    task automatic send(input vec_t v);
        int n;
        drive(v);
        n = 0;
        @(negedge forever_cpuclk);
        while (!in_rdy && n < 50) begin
            n++;
            @(negedge forever_cpuclk);
        end
        if (!in_rdy) check_eq("send_timeout", 64'(in_rdy), 64'd1);
        @(posedge forever_cpuclk);
        #1;
        in_vld = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            n++;
            @(posedge forever_cpuclk);
            #1;
        end
        check_eq("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        vt[0]  = mk(32'h3F800000, 32'h00000000, 1, 0, 0, 32'h7F800000, 8'h04, 4'h0, 5'h08, 1, 4'b0010);
        vt[1]  = mk(32'h00000000, 32'h00000000, 1, 0, 0, 32'h7FC00000, 8'h10, 4'h0, 5'h10, 1, 4'b0000);
        vt[2]  = mk(32'hC0800000, 32'h00000000, 0, 1, 0, 32'h7FC00000, 8'h10, 4'hE, 5'h10, 1, 4'b0010);
        vt[3]  = mk(32'h7F800001, 32'h3F800000, 1, 0, 1, 32'h7FC00001, 8'h20, 4'h0, 5'h10, 1, 4'b0001);
        vt[4]  = mk(32'h7F800001, 32'h3F800000, 1, 0, 0, 32'h7FC00000, 8'h10, 4'h0, 5'h10, 1, 4'b0001);
        vt[5]  = mk(32'h40000000, 32'h3F800000, 1, 0, 0, 32'h00000000, 8'h00, 4'h0, 5'h00, 0, 4'b0011);
        vt[6]  = mk(32'h80000000, 32'h40400000, 1, 0, 0, 32'h80000000, 8'h02, 4'hE, 5'h00, 1, 4'b0001);
        vt[7]  = mk(32'hC0000000, 32'hFF800000, 1, 0, 0, 32'h00000000, 8'h02, 4'h0, 5'h00, 1, 4'b0010);
        vt[8]  = mk(32'h7F800000, 32'h00000000, 0, 1, 0, 32'h7F800000, 8'h04, 4'h0, 5'h00, 1, 4'b0000);
        vt[9]  = mk(32'hFFC01234, 32'h3F800000, 1, 0, 1, 32'hFFC01234, 8'h20, 4'hE, 5'h00, 1, 4'b0001);
        vt[10] = mk(32'h3F800000, 32'h7FC00000, 1, 0, 1, 32'h7FC00000, 8'h10, 4'h0, 5'h00, 1, 4'b0010);
        vt[11] = mk(32'h00000000, 32'h7F800001, 0, 0, 1, 32'h00000000, 8'h00, 4'h0, 5'h00, 0, 4'b0000);
        vt[12] = mk(32'h00400000, 32'h00000000, 1, 0, 0, 32'h7F800000, 8'h04, 4'h0, 5'h08, 1, 4'b1010);
        vt[13] = mk(32'hFF800000, 32'h00000000, 0, 1, 0, 32'h7FC00000, 8'h10, 4'hE, 5'h10, 1, 4'b0000);
        vt[14] = mk(32'h7F800000, 32'h7F800000, 1, 0, 0, 32'h7FC00000, 8'h10, 4'h0, 5'h10, 1, 4'b0000);
        vt[15] = mk(32'h7FC00005, 32'h7F800002, 1, 0, 1, 32'h7FC00002, 8'h40, 4'h0, 5'h10, 1, 4'b0000);

        cpurst_b = 1'b0;
        in_vld   = 1'b0;
        in_op0   = '0;
        in_op1   = '0;
        in_div   = 1'b0;
        in_sqrt  = 1'b0;
        in_dqnan = 1'b0;
        flush    = 1'b0;
        out_rdy  = 1'b1;
        drv_vec  = '0;
        done     = 1'b0;
`ifdef FDSU_SPECIAL_FFLAGS_ACC_EN
        acc_clr  = 1'b0;
`endif
        repeat (3) @(negedge forever_cpuclk);
        check_eq("rst_out_vld", 64'(out_vld), 64'd0);
        check_eq("rst_in_rdy", 64'(in_rdy), 64'd1);
        check_eq("rst_result", 64'(out_result), 64'd0);
        check_eq("rst_sel", 64'(out_special_sel), 64'd0);
        check_eq("rst_fflags", 64'(out_fflags), 64'd0);
`ifdef FDSU_SPECIAL_FFLAGS_ACC_EN
        check_eq("rst_acc", 64'(acc_fflags), 64'd0);
`endif
        @(posedge forever_cpuclk);
        #1;
        cpurst_b = 1'b1;
        @(posedge forever_cpuclk);
        #1;

        // Two-cycle latency on 1/0
        drive(vt[0]);
        @(negedge forever_cpuclk);
        check_eq("lat_in_rdy", 64'(in_rdy), 64'd1);
        @(posedge forever_cpuclk);
        #1;
        in_vld = 1'b0;
        @(negedge forever_cpuclk);
        check_eq("lat_cycle1_vld", 64'(out_vld), 64'd0);
        @(negedge forever_cpuclk);
        check_eq("lat_cycle2_vld", 64'(out_vld), 64'd1);
        @(posedge forever_cpuclk);
        #1;
        drain();

        // Full table back-to-back, consumer always ready
        for (int i = 1; i < 16; i++) send(vt[i]);
        drain();

        // Full table again under random consumer backpressure
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 16; i++) send(vt[i]);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge forever_cpuclk);
                    #1;
                    out_rdy = 1'($urandom_range(0, 1));
                end
                out_rdy = 1'b1;
            end
        join
        drain();

        // Four back-to-back with a three-cycle output stall
        out_rdy = 1'b0;
        base = n_acc;
        fork
            begin
                send(vt[5]);
                send(vt[6]);
                send(vt[7]);
                send(vt[8]);
            end
            begin
                n = 0;
                @(negedge forever_cpuclk);
                while (!out_vld && n < 20) begin
                    n++;
                    @(negedge forever_cpuclk);
                end
                check_eq("stall_out_vld", 64'(out_vld), 64'd1);
                check_eq("stall_accepted", 64'(n_acc - base), 64'd2);
                for (int k = 0; k < 3; k++) begin
                    check_eq("stall_in_rdy", 64'(in_rdy), 64'd0);
                    check_eq("stall_hold_vld", 64'(out_vld), 64'd1);
                    check_eq("stall_hold_res", 64'(out_result), 64'(vt[5].res));
                    check_eq("stall_hold_idn",
                             64'({out_op0_id, out_op1_id, out_op0_norm, out_op1_norm}),
                             64'(vt[5].idn));
                    if (k < 2) @(negedge forever_cpuclk);
                end
                @(posedge forever_cpuclk);
                #1;
                out_rdy = 1'b1;
            end
        join
        drain();
        check_eq("stall_total_acc", 64'(n_acc - base), 64'd4);

        // Flush with two entries in flight plus a new input
        out_rdy = 1'b0;
        send(vt[1]);
        send(vt[3]);
        drive(vt[12]);
        flush = 1'b1;
        @(posedge forever_cpuclk);
        #1;
        flush  = 1'b0;
        in_vld = 1'b0;
        @(negedge forever_cpuclk);
        check_eq("flush_out_vld", 64'(out_vld), 64'd0);
        check_eq("flush_in_rdy", 64'(in_rdy), 64'd1);
        check_eq("flush_sb_empty", 64'(sb_q.size()), 64'd0);
        out_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge forever_cpuclk);
            check_eq("flush_no_delivery", 64'(out_vld), 64'd0);
        end
        @(posedge forever_cpuclk);
        #1;

        // Flush while the pipe is ready drops the same-cycle input
        drive(vt[2]);
        flush = 1'b1;
        @(posedge forever_cpuclk);
        #1;
        flush  = 1'b0;
        in_vld = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge forever_cpuclk);
            check_eq("flush_drop", 64'(out_vld), 64'd0);
        end
        @(posedge forever_cpuclk);
        #1;
        send(vt[9]);
        drain();

`ifdef FDSU_SPECIAL_FFLAGS_ACC_EN
        // Sticky accumulation, clear, and clear coincident with delivery
        acc_clr = 1'b1;
        @(posedge forever_cpuclk);
        #1;
        acc_clr = 1'b0;
        @(negedge forever_cpuclk);
        check_eq("acc_after_clr0", 64'(acc_fflags), 64'd0);
        @(posedge forever_cpuclk);
        #1;
        send(vt[1]);
        send(vt[0]);
        drain();
        @(negedge forever_cpuclk);
        check_eq("acc_nv_dz", 64'(acc_fflags), 64'h18);
        @(posedge forever_cpuclk);
        #1;
        acc_clr = 1'b1;
        @(posedge forever_cpuclk);
        #1;
        acc_clr = 1'b0;
        @(negedge forever_cpuclk);
        check_eq("acc_cleared", 64'(acc_fflags), 64'd0);
        @(posedge forever_cpuclk);
        #1;
        send(vt[1]);
        drain();
        out_rdy = 1'b0;
        send(vt[0]);
        @(posedge forever_cpuclk);
        #1;
        check_eq("acc_pre_clr", 64'(acc_fflags), 64'h10);
        out_rdy = 1'b1;
        acc_clr = 1'b1;
        @(posedge forever_cpuclk);
        #1;
        acc_clr = 1'b0;
        @(negedge forever_cpuclk);
        check_eq("acc_clr_with_fire", 64'(acc_fflags), 64'h08);
        @(posedge forever_cpuclk);
        #1;
        drain();
`endif

        // Reset in the middle of an operation discards it
        out_rdy = 1'b0;
        send(vt[0]);
        @(posedge forever_cpuclk);
        #1;
        check_eq("pre_rst_vld", 64'(out_vld), 64'd1);
        cpurst_b = 1'b0;
        #1;
        check_eq("mid_rst_vld", 64'(out_vld), 64'd0);
        check_eq("mid_rst_result", 64'(out_result), 64'd0);
        check_eq("mid_rst_fflags", 64'(out_fflags), 64'd0);
        check_eq("mid_rst_in_rdy", 64'(in_rdy), 64'd1);
        @(negedge forever_cpuclk);
        @(posedge forever_cpuclk);
        #1;
        cpurst_b = 1'b1;
        out_rdy  = 1'b1;
        @(posedge forever_cpuclk);
        #1;
        send(vt[8]);
        drain();
        repeat (2) @(negedge forever_cpuclk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pa_fdsu_special_pipe.md
PA_FDSU_SPECIAL_PIPE -- requirements
Module: pa_fdsu_special_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8: exponent width.
REQ-002 SHALL have parameter MAN_W, default 23: mantissa width. FLEN = 1+EXP_W+MAN_W.
REQ-003 SHALL have ports forever_cpuclk (in, 1, sole clock) and cpurst_b (in, 1, reset, asynchronous, active-low).
REQ-004 SHALL have ports in_vld (in, 1) and in_rdy (out, 1): input handshake.
REQ-005 SHALL have ports in_op0, in_op1 (in, FLEN): raw operands; in_div, in_sqrt (in, 1): one-hot op; in_dqnan (in, 1): 1 = propagate NaN payload, 0 = canonical NaN.
REQ-006 SHALL have port flush (in, 1): kill all in-flight entries.
REQ-007 SHALL have ports out_vld (out, 1) and out_rdy (in, 1): output handshake.
REQ-008 SHALL have ports out_special_sel (out, 8; {0,qnan_op1,qnan_op0,cnan,lfn,inf,zero,0}), out_special_sign (out, 4; {sign,sign,sign,0}), out_fflags (out, 5; {NV,DZ,OF,UF,NX}), out_srt_skip (out, 1), out_op0_id, out_op1_id, out_op0_norm, out_op1_norm (out, 1 each), out_result (out, FLEN; final special value, valid when out_srt_skip=1).
REQ-009 SHALL have port acc_fflags (out, 5) when FDSU_SPECIAL_FFLAGS_ACC_EN is defined, and acc_clr (in, 1).

Function
REQ-010 SHALL classify each operand from raw bits: exp all-ones & man==0 -> inf; exp all-ones & man MSB=1 -> qnan; exp all-ones & man!=0 & MSB=0 -> snan; exp==0 & man==0 -> zero; exp==0 & man!=0 -> id; cnan = qnan & sign=0 & man==MSB-only; norm = none of inf/zero/qnan/snan/cnan (id counts as norm).
REQ-011 SHALL set NV = div&(snan0|snan1|zero0&zero1|inf0&inf1) | sqrt&(snan0|sign0&(norm0|inf0)); DZ = div&zero1&norm0; OF=UF=NX=0; lfn=0.
REQ-012 SHALL set zero result = div&(zero0&norm1 | !inf0&!qnan0&!snan0&!cnan0&inf1) | sqrt&zero0; inf result = div&inf0&!inf1&!qnan1&!snan1&!cnan1 | sqrt&inf0&!sign0 | DZ; qnan result = div&(qnan0|qnan1) | sqrt&qnan0 | NV.
REQ-013 SHALL select NaN source by priority: default-NaN case (0/0, inf/inf, sqrt negative) -> cnan; else dqnan&snan0 -> op0; dqnan&div&snan1 -> op1; dqnan&qnan0 -> op0 (cnan if op0 canonical); dqnan&div&qnan1 -> op1 (cnan if op1 canonical); else cnan.
REQ-014 SHALL compute sign = div ? sign0^sign1 : sign0.
REQ-015 SHALL build out_result: cnan -> {0,ones,1,0..0}; qnan_opN -> {signN,ones,1,manN[MAN_W-2:0]} (quieted); inf -> {sign,ones,0}; zero -> {sign,0,0}; else all zero.
REQ-016 SHALL set out_srt_skip = zero|inf|qnan|lfn.
REQ-017 SHALL be a 2-stage pipeline: S1 registers classification, op, dqnan; S2 registers resolved outputs; latency 2 cycles in->out with no stall.
REQ-018 SHALL advance stage k when stage k empty or stage k+1 advancing; in_rdy = !S1_vld | S1 advancing (combinational from out_rdy allowed); full throughput 1/cycle.
REQ-019 SHALL hold all out_* stable while out_vld=1 & out_rdy=0.
REQ-020 SHALL on flush clear both stage valids next edge and drop a same-cycle input; flush has priority over accept.
REQ-021 SHALL treat in_div=in_sqrt=0 as all-zero results, no flags.

Reset
REQ-022 SHALL on cpurst_b=0 clear S1/S2 valids, all out_* to 0, acc_fflags to 0; in_rdy=1 after reset; reset mid-operation discards entries.

Configuration
REQ-023 SHALL with FDSU_SPECIAL_FFLAGS_ACC_EN defined OR out_fflags into acc_fflags on each out_vld&out_rdy; acc_clr clears, and concurrent accept yields only the new flags; without the macro acc_fflags/acc_clr absent, no accumulator flops.

Structure
REQ-024 SHALL place in shared package pa_fdsu_pkg: operand-class struct (inf,zero,id,cnan,snan,qnan,norm), special_sel bit-index constants, fflags bit-index constants.
REQ-025 SHALL instantiate classifier sub-module pa_fdsu_op_class (param EXP_W, MAN_W), once per operand.

Verification (EXP_W=8, MAN_W=23)
REQ-026 SHALL cover div 0x3F800000/0x00000000 -> result 0x7F800000, inf=1, DZ=1, srt_skip=1, out_vld 2 cycles after accept.
REQ-027 SHALL cover div 0x00000000/0x00000000 and sqrt 0xC0800000 -> 0x7FC00000, cnan=1, NV=1.
REQ-028 SHALL cover div 0x7F800001/0x3F800000, dqnan=1 -> 0x7FC00001, qnan_op0=1, NV=1; dqnan=0 -> 0x7FC00000, cnan=1.
REQ-029 SHALL cover 4 back-to-back ops with out_rdy=0 for 3 cycles -> in_rdy low after 2 accepted, outputs stable, all 4 delivered in order.
REQ-030 SHALL cover flush with 2 entries in flight plus in_vld -> out_vld=0 next cycle, no delivery; with the macro, acc_fflags 0x18 after 0/0 then 1/0, 0 after acc_clr.
